// File: rtl/exibidor_sequencia.sv
// Presents a stored colour sequence on the LEDs: each element is shown for an
// on-time followed by a dark gap, with a fast mode that halves both timings.
module exibidor_sequencia #(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic       dificuldade,
    input  logic [3:0] dado_memoria,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       fim,
    output logic [2:0] db_estado
);

    localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] SHOW = 3'd2;
    localparam logic [2:0] GAP  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    // Terminal timer values: a phase of N cycles ends when the timer reads N-1.
    localparam logic [TW-1:0] ON_FULL  = TW'(T_ON - 1);
    localparam logic [TW-1:0] ON_FAST  = TW'(T_ON / 2 - 1);
    localparam logic [TW-1:0] OFF_FULL = TW'(T_OFF - 1);
    localparam logic [TW-1:0] OFF_FAST = TW'(T_OFF / 2 - 1);

    logic [2:0]    estado_r;
    logic [TW-1:0] timer_r;
    logic [3:0]    limite_r;
    logic          dificuldade_r;
    logic [3:0]    endereco_r;
    logic [3:0]    leds_r;
    logic          ocupado_r;
    logic          fim_r;

    logic [TW-1:0] on_last_s;
    logic [TW-1:0] gap_last_s;
    logic          show_end_s;
    logic          gap_end_s;

    // Phase-end detection using the timings latched at start.
    always_comb begin
        on_last_s  = ON_FULL;
        gap_last_s = OFF_FULL;
        if (dificuldade_r) begin
            on_last_s  = ON_FAST;
            gap_last_s = OFF_FAST;
        end else begin
            on_last_s  = ON_FULL;
            gap_last_s = OFF_FULL;
        end
        show_end_s = (timer_r == on_last_s);
        gap_end_s  = (timer_r == gap_last_s);
    end

    // Sequencer FSM; all outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r      <= IDLE;
            timer_r       <= '0;
            limite_r      <= 4'd0;
            dificuldade_r <= 1'b0;
            endereco_r    <= 4'd0;
            leds_r        <= 4'd0;
            ocupado_r     <= 1'b0;
            fim_r         <= 1'b0;
        end else begin
            case (estado_r)
                IDLE: begin
                    timer_r <= '0;
                    leds_r  <= 4'd0;
                    fim_r   <= 1'b0;
                    if (iniciar) begin
                        limite_r      <= limite;
                        dificuldade_r <= dificuldade;
                        endereco_r    <= 4'd0;
                        ocupado_r     <= 1'b1;
                        estado_r      <= PREP;
                    end else begin
                        ocupado_r <= 1'b0;
                        estado_r  <= IDLE;
                    end
                end
                PREP: begin
                    leds_r   <= dado_memoria;
                    timer_r  <= '0;
                    estado_r <= SHOW;
                end
                SHOW: begin
                    if (show_end_s) begin
                        leds_r   <= 4'd0;
                        timer_r  <= '0;
                        estado_r <= GAP;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_end_s) begin
                        timer_r <= '0;
                        // Last element: address is held, never wrapped.
                        if (endereco_r == limite_r) begin
                            ocupado_r <= 1'b0;
                            fim_r     <= 1'b1;
                            estado_r  <= DONE;
                        end else begin
                            endereco_r <= endereco_r + 4'd1;
                            estado_r   <= PREP;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                DONE: begin
                    fim_r    <= 1'b0;
                    estado_r <= IDLE;
                end
                default: begin
                    timer_r   <= '0;
                    leds_r    <= 4'd0;
                    ocupado_r <= 1'b0;
                    fim_r     <= 1'b0;
                    estado_r  <= IDLE;
                end
            endcase
        end
    end

    assign endereco  = endereco_r;
    assign leds      = leds_r;
    assign ocupado   = ocupado_r;
    assign fim       = fim_r;
    assign db_estado = estado_r;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Self-checking bench: builds the expected per-cycle trace of each run from
// the element/on/gap/done rules and compares it against the DUT every cycle.
module tb_exibidor_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic       dificuldade;
    logic [3:0] dado_memoria;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim;
    logic [2:0] db_estado;

    logic [3:0] mem [16];
    int tests = 0;
    int fails = 0;

    exibidor_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .limite       (limite),
        .dificuldade  (dificuldade),
        .dado_memoria (dado_memoria),
        .endereco     (endereco),
        .leds         (leds),
        .ocupado      (ocupado),
        .fim          (fim),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Memory read data is available during the cycle following an address change.
    assign dado_memoria = mem[endereco];

    // Observation word: {state, leds, address, busy, done}.
    function automatic logic [12:0] pack(input logic [2:0] st, input logic [3:0] l,
                                         input logic [3:0] a, input logic oc, input logic f);
        return {st, l, a, oc, f};
    endfunction

    function automatic logic [12:0] obs();
        return {db_estado, leds, endereco, ocupado, fim};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got st=%0d leds=%b end=%0d oc=%b fim=%b, expected st=%0d leds=%b end=%0d oc=%b fim=%b",
                   tag, got[12:10], got[9:6], got[5:2], got[1], got[0],
                   exp[12:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Runs one presentation; abort_at >= 0 applies reset after that trace cycle.
    task automatic run_seq(input int lim, input bit dif, input bit chaos,
                           input bit hold, input int abort_at);
        logic [12:0] exp_q[$];
        int on_t;
        int gap_t;
        on_t  = dif ? T_ON / 2 : T_ON;
        gap_t = dif ? T_OFF / 2 : T_OFF;
        for (int e = 0; e <= lim; e++) begin
            exp_q.push_back(pack(3'd1, 4'd0, 4'(e), 1'b1, 1'b0));
            for (int c = 0; c < on_t; c++) exp_q.push_back(pack(3'd2, mem[e], 4'(e), 1'b1, 1'b0));
            for (int c = 0; c < gap_t; c++) exp_q.push_back(pack(3'd3, 4'd0, 4'(e), 1'b1, 1'b0));
        end
        exp_q.push_back(pack(3'd4, 4'd0, 4'(lim), 1'b0, 1'b1));
        exp_q.push_back(pack(3'd0, 4'd0, 4'(lim), 1'b0, 1'b0));

        iniciar     = 1'b1;
        limite      = 4'(lim);
        dificuldade = dif;
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            check($sformatf("run lim=%0d dif=%0d cyc=%0d", lim, dif, i), obs(), exp_q[i]);
            if (i == abort_at) begin
                reset   = 1'b1;
                iniciar = 1'b0;
                tick();
                reset = 1'b0;
                check("reset mid-show", obs(), pack(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));
                for (int j = 0; j < 4; j++) begin
                    tick();
                    check($sformatf("post-reset idle %0d", j), obs(), pack(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));
                end
                return;
            end
            if (hold) begin
                iniciar = 1'b1;
            end else if (chaos && exp_q[i][12:10] != 3'd4 && exp_q[i][12:10] != 3'd0) begin
                iniciar     = 1'($urandom_range(1));
                limite      = 4'($urandom);
                dificuldade = 1'($urandom_range(1));
            end else begin
                iniciar = 1'b0;
            end
        end
        if (!hold) iniciar = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 4'd0;
        reset       = 1'b1;
        iniciar     = 1'b0;
        limite      = 4'd0;
        dificuldade = 1'b0;
        tick();
        tick();
        check("reset state", obs(), pack(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));

        // Reset wins over a simultaneous start request.
        iniciar = 1'b1;
        tick();
        check("reset priority", obs(), pack(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        reset   = 1'b0;
        iniciar = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("idle hold", obs(), pack(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        end

        // Single element.
        mem[0] = 4'b0010;
        run_seq(0, 1'b0, 1'b0, 1'b0, -1);

        // Three elements, normal speed.
        mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
        run_seq(2, 1'b0, 1'b0, 1'b0, -1);

        // Fast mode with inputs churning mid-run.
        run_seq(1, 1'b1, 1'b1, 1'b0, -1);

        // Reset during SHOW of element 1, then a clean restart.
        run_seq(2, 1'b0, 1'b0, 1'b0, 9);
        run_seq(1, 1'b0, 1'b0, 1'b0, -1);

        // Full-length sequence with start pulses while busy.
        for (int a = 0; a < 16; a++) mem[a] = 4'(4'b0001 << $urandom_range(3));
        run_seq(15, 1'b0, 1'b1, 1'b0, -1);

        // Start held high through DONE: restart only after returning to IDLE.
        run_seq(0, 1'b0, 1'b0, 1'b1, -1);
        tick();
        check("restart from idle", obs(), pack(3'd1, 4'd0, 4'd0, 1'b1, 1'b0));
        iniciar = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        check("reset after restart", obs(), pack(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) mem[a] = 4'(4'b0001 << $urandom_range(3));
            run_seq(int'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, -1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
